// File: rtl/if_prefetch_unit_pkg.sv
// Shared widths, constants, FSM encoding and queue entry layout for the
// instruction prefetch unit.
package if_prefetch_unit_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_W-1:0] ZERO_WORD    = '0;
  localparam logic              CHIP_ENABLE  = 1'b1;
  localparam logic              CHIP_DISABLE = 1'b0;

  // Default queue depth is 2**PREFETCH_DEPTH_LOG2 entries.
  localparam int PREFETCH_DEPTH_LOG2 = 2;

  typedef enum logic {
    IF_STATE_WAIT = 1'b0,
    IF_STATE_RUN  = 1'b1
  } if_state_e;

  // One queued fetch: the PC it came from and the word the ROM returned.
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } prefetch_entry_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Small prefetch queue: synchronous write, combinational head read,
// occupancy count and a flush that empties it in one edge.
module if_prefetch_fifo
  import if_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  prefetch_entry_t      wr_data,
  output prefetch_entry_t      rd_data,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  prefetch_entry_t mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;

  // Per-entry storage; an entry is written only when it is the push target.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && !flush && wr_ptr_reg == AW'(gi)) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Pointer and count update; flush wins over push/pop, pointers wrap naturally.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      if (push && !pop)      count_next = count_reg + 1'b1;
      else if (pop && !push) count_next = count_reg - 1'b1;
    end
  end

  // Queue control registers, cleared asynchronously so nothing survives reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign rd_data = mem_reg[rd_ptr_reg];
  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch initiator: drives the combinational ROM port, queues
// {pc, inst} pairs and presents the queue head to decode with valid/ready.
// A redirect empties the queue and restarts fetch at the new word address.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int                     DEPTH    = 2 ** PREFETCH_DEPTH_LOG2,
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rom_ce,
  output logic [INST_ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0]      rom_inst,
  input  logic                   redirect_i,
  input  logic [INST_ADDR_W-1:0] redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INST_W-1:0]      out_inst,
  output logic [INST_ADDR_W-1:0] out_pc
);

  if_state_e              state_reg, state_next;
  logic [INST_ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic                   fifo_full, fifo_empty, pop;
  prefetch_entry_t        wr_entry, head_entry;

  // FSM next state and the fetch/handshake strobes derived from it.
  always_comb begin
    state_next = state_reg;
    rom_ce     = CHIP_DISABLE;
    out_valid  = 1'b0;
    if (state_reg == IF_STATE_WAIT) begin
      state_next = IF_STATE_RUN;
    end
    // Fullness is taken before any same-cycle pop, so a full queue skips one fetch.
    if (state_reg == IF_STATE_RUN && !fifo_full && !redirect_i) begin
      rom_ce = CHIP_ENABLE;
    end
    out_valid = !fifo_empty && !redirect_i;
  end

  assign pop = out_valid && out_ready;

  // Fetch address: redirect target (word aligned) or sequential advance on a push.
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (redirect_i) begin
      fetch_pc_next = redirect_pc & ~32'h3;
    end else if (rom_ce) begin
      fetch_pc_next = fetch_pc_reg + 32'd4;
    end
  end

  // State and fetch PC registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IF_STATE_WAIT;
      fetch_pc_reg <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
    end
  end

  assign rom_addr      = fetch_pc_reg;
  assign wr_entry.pc   = fetch_pc_reg;
  assign wr_entry.inst = rom_inst;

  if_prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_i),
    .push    (rom_ce),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_inst = out_valid ? head_entry.inst : ZERO_WORD;
  assign out_pc   = out_valid ? head_entry.pc   : '0;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: startup latency, back-pressure,
// full-with-pop, redirect flush, asynchronous mid-stream reset and PC wrap.
module tb_if_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  // Second instance starting near the top of the address space.
  logic        w_rst = 1'b0;
  logic        w_rom_ce;
  logic [31:0] w_rom_addr;
  logic [31:0] w_rom_inst;
  logic        w_out_valid;
  logic [31:0] w_out_inst;
  logic [31:0] w_out_pc;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // ROM contents: word at byte address N is 0x1000_0000 + N.
  assign rom_inst   = 32'h1000_0000 + rom_addr;
  assign w_rom_inst = 32'h1000_0000 + w_rom_addr;

  if_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce      (rom_ce),
    .rom_addr    (rom_addr),
    .rom_inst    (rom_inst),
    .redirect_i  (redirect_i),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc)
  );

  if_prefetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk         (clk),
    .rst         (w_rst),
    .rom_ce      (w_rom_ce),
    .rom_addr    (w_rom_addr),
    .rom_inst    (w_rom_inst),
    .redirect_i  (1'b0),
    .redirect_pc (32'h0),
    .out_valid   (w_out_valid),
    .out_ready   (1'b1),
    .out_inst    (w_out_inst),
    .out_pc      (w_out_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s obs=%h exp=%h", vectors, tag, obs, exp);
  endtask

  initial begin
    int          pushes;
    logic [31:0] exp_pc;

    // Reset state
    #1;
    check("reset rom_ce", {31'b0, rom_ce}, 32'h0);
    check("reset rom_addr", rom_addr, 32'h0);
    check("reset out_valid", {31'b0, out_valid}, 32'h0);
    check("reset out_inst", out_inst, 32'h0);
    check("reset out_pc", out_pc, 32'h0);

    // Release reset; first edge enters RUN, second edge pushes PC 0
    @(negedge clk); rst = 1'b1; out_ready = 1'b1;
    #1;
    check("wait rom_ce", {31'b0, rom_ce}, 32'h0);
    @(negedge clk); #1;
    check("run rom_ce", {31'b0, rom_ce}, 32'h1);
    check("run rom_addr", rom_addr, 32'h0);
    check("run out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk); #1;
    check("first out_valid", {31'b0, out_valid}, 32'h1);
    check("first out_pc", out_pc, 32'h0);
    check("first out_inst", out_inst, 32'h1000_0000);
    @(negedge clk); #1;
    check("stream pc4", out_pc, 32'h4);
    @(negedge clk); #1;
    check("stream pc8", out_pc, 32'h8);
    check("stream inst8", out_inst, 32'h1000_0008);

    // Redirect to 0 and hold out_ready low: exactly four pushes then stall
    @(negedge clk); redirect_i = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0;
    #1;
    check("bp redirect out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk); redirect_i = 1'b0;
    #1;
    pushes = int'(rom_ce);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); #1;
      pushes += int'(rom_ce);
    end
    check("bp push count", 32'(pushes), 32'd4);
    check("bp full rom_ce", {31'b0, rom_ce}, 32'h0);
    check("bp full rom_addr", rom_addr, 32'h10);
    check("bp head pc", out_pc, 32'h0);

    // Full queue with a pop: no push this cycle, fetch resumes next cycle
    @(negedge clk); out_ready = 1'b1;
    #1;
    check("fullpop rom_ce", {31'b0, rom_ce}, 32'h0);
    check("fullpop out_pc", out_pc, 32'h0);
    check("fullpop out_inst", out_inst, 32'h1000_0000);
    @(negedge clk); out_ready = 1'b0;
    #1;
    check("resume rom_ce", {31'b0, rom_ce}, 32'h1);
    check("resume rom_addr", rom_addr, 32'h10);
    check("resume head pc", out_pc, 32'h4);
    @(negedge clk); out_ready = 1'b1;
    #1;
    check("refull rom_ce", {31'b0, rom_ce}, 32'h0);
    check("refull rom_addr", rom_addr, 32'h14);
    // Drain in order: 4, 8, C, 10, 14 with nothing lost or repeated
    exp_pc = 32'h4;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin
        @(negedge clk); #1;
      end
      check("order pc", out_pc, exp_pc);
      check("order inst", out_inst, 32'h1000_0000 + exp_pc);
      exp_pc += 32'h4;
    end

    // Redirect with three entries queued
    @(negedge clk); redirect_i = 1'b1; redirect_pc = 32'h0000_0203;
    #1;
    check("redir out_valid", {31'b0, out_valid}, 32'h0);
    check("redir rom_ce", {31'b0, rom_ce}, 32'h0);
    check("redir out_inst", out_inst, 32'h0);
    @(negedge clk); redirect_i = 1'b0;
    #1;
    check("redir rom_addr", rom_addr, 32'h200);
    check("redir rom_ce next", {31'b0, rom_ce}, 32'h1);
    check("redir no stale", {31'b0, out_valid}, 32'h0);
    @(negedge clk); #1;
    check("redir target valid", {31'b0, out_valid}, 32'h1);
    check("redir target pc", out_pc, 32'h200);
    check("redir target inst", out_inst, 32'h1000_0200);
    out_ready = 1'b0;
    @(negedge clk); #1;
    check("two queued head", out_pc, 32'h200);

    // Asynchronous reset in the middle of the low clock phase
    #2 rst = 1'b0;
    #1;
    check("async rom_ce", {31'b0, rom_ce}, 32'h0);
    check("async rom_addr", rom_addr, 32'h0);
    check("async out_valid", {31'b0, out_valid}, 32'h0);
    check("async out_inst", out_inst, 32'h0);
    check("async out_pc", out_pc, 32'h0);
    @(negedge clk); rst = 1'b1; out_ready = 1'b1;
    @(negedge clk); #1;
    check("rerun rom_ce", {31'b0, rom_ce}, 32'h1);
    check("rerun rom_addr", rom_addr, 32'h0);
    check("rerun out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk); #1;
    check("rerun out_pc", out_pc, 32'h0);
    check("rerun out_valid2", {31'b0, out_valid}, 32'h1);

    // PC wrap from the top of the address space
    @(negedge clk); w_rst = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    check("wrap pc0", w_out_pc, 32'hFFFF_FFF8);
    check("wrap inst0", w_out_inst, 32'h1000_0000 + 32'hFFFF_FFF8);
    @(negedge clk); #1;
    check("wrap pc1", w_out_pc, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("wrap pc2", w_out_pc, 32'h0000_0000);
    check("wrap inst2", w_out_inst, 32'h1000_0000);
    @(negedge clk); #1;
    check("wrap pc3", w_out_pc, 32'h0000_0004);
    check("wrap valid", {31'b0, w_out_valid}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
